// File: rtl/dds_voice_engine_if.sv
// Bus bundle for the DDS voice engine: frame request, shadowed config
// write port from the SPI command decoder, and the mixed sample output
// towards the DAC SPI master.
interface dds_voice_engine_if #(
  parameter int NUM_VOICES = 4,
  parameter int TUNE_W     = 16,
  parameter int OUT_W      = 16
) ();
  localparam int VOICE_W = $clog2(NUM_VOICES);

  logic               sample_tick;
  logic               cfg_we;
  logic [VOICE_W-1:0] cfg_voice;
  logic [1:0]         cfg_field;
  logic [TUNE_W-1:0]  cfg_data;
  logic [OUT_W-1:0]   out_sample;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output sample_tick, cfg_we, cfg_voice, cfg_field, cfg_data,
    input  out_sample, out_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_voice, cfg_field, cfg_data,
    output out_sample, out_valid, busy, overrun
  );
endinterface

// File: rtl/dds_voice_engine.sv
// N-voice DDS engine. A single waveform/mix datapath is shared by all
// voices, one voice per clock, once per accepted sample_tick. Config
// writes land in shadow registers and take effect atomically at the
// next accepted tick so a frame never sees a half-written voice.
module dds_voice_engine #(
  parameter int NUM_VOICES = 4,
  parameter int TUNE_W     = 16,
  parameter int ACC_W      = 20,
  parameter int PHASE_W    = 14,
  parameter int WAVE_W     = 12,
  parameter int OUT_W      = 16
) (
  input  logic                sys_clk,
  input  logic                rst,
  dds_voice_engine_if.slave   bus
);

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int SUM_W   = WAVE_W + VOICE_W;
  localparam int SHIFT   = OUT_W - SUM_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
  localparam logic [WAVE_W-1:0]  WAVE_MSB   = {1'b1, {(WAVE_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]   OUT_MID    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [15:0]        LFSR_SEED  = 16'hACE1;

  // x^16+x^14+x^13+x^11, shifting towards bit 0, new bit enters at 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
  endfunction

  // Shadow (host-written) and active (frame-visible) per-voice config.
  logic [TUNE_W-1:0] sh_tune_r  [NUM_VOICES];
  logic [6:0]        sh_ctrl_r  [NUM_VOICES];
  logic [WAVE_W-1:0] sh_pw_r    [NUM_VOICES];
  logic [TUNE_W-1:0] act_tune_r [NUM_VOICES];
  logic [6:0]        act_ctrl_r [NUM_VOICES];
  logic [WAVE_W-1:0] act_pw_r   [NUM_VOICES];
  logic [ACC_W-1:0]  acc_r      [NUM_VOICES];

  logic [1:0]               state_r;
  logic [VOICE_W-1:0]       voice_r;
  logic [15:0]              lfsr_r;
  logic signed [SUM_W-1:0]  sum_r;
  logic [OUT_W-1:0]         out_sample_r;
  logic                     out_valid_r;
  logic                     busy_r;
  logic                     overrun_r;

  logic                     tick_accept_s;
  logic [6:0]               ctrl_s;
  logic                     en_s;
  logic                     pr_s;
  logic [2:0]               mode_s;
  logic [1:0]               atten_s;
  logic [PHASE_W-1:0]       phase_s;
  logic [WAVE_W-1:0]        t_s;
  logic [WAVE_W-1:0]        wave_s;
  logic signed [WAVE_W-1:0] scaled_s;
  logic signed [SUM_W-1:0]  contrib_s;
  logic signed [SUM_W-1:0]  sum_next_s;
  logic [OUT_W-1:0]         out_word_s;
  logic [ACC_W-1:0]         acc_next_s;
  logic                     noise_step_s;
  logic                     unused_s;

  assign tick_accept_s = bus.sample_tick && (state_r == ST_IDLE);

  // Evaluate the voice selected by voice_r: phase, waveform, attenuation, mix.
  always_comb begin
    ctrl_s   = act_ctrl_r[voice_r];
    en_s     = ctrl_s[0];
    pr_s     = ctrl_s[1];
    mode_s   = ctrl_s[4:2];
    atten_s  = ctrl_s[6:5];
    phase_s  = pr_s ? {PHASE_W{1'b0}} : acc_r[voice_r][ACC_W-1 -: PHASE_W];
    t_s      = phase_s[PHASE_W-1 -: WAVE_W];
    wave_s   = WAVE_MSB;
    case (mode_s)
      3'd0: wave_s = t_s;
      3'd1: wave_s = (t_s < act_pw_r[voice_r]) ? {WAVE_W{1'b1}} : {WAVE_W{1'b0}};
      3'd2: wave_s = phase_s[PHASE_W-1] ? ~phase_s[PHASE_W-2 -: WAVE_W]
                                        :  phase_s[PHASE_W-2 -: WAVE_W];
      3'd3: wave_s = lfsr_r[15 -: WAVE_W];
      default: wave_s = WAVE_MSB;
    endcase
    scaled_s     = $signed(wave_s ^ WAVE_MSB) >>> atten_s;
    contrib_s    = en_s ? SUM_W'(scaled_s) : {SUM_W{1'b0}};
    sum_next_s   = sum_r + contrib_s;
    out_word_s   = (OUT_W'(sum_next_s) << SHIFT) ^ OUT_MID;
    noise_step_s = en_s && (mode_s == 3'd3);
    if (!en_s) begin
      acc_next_s = acc_r[voice_r];
    end else if (pr_s) begin
      acc_next_s = {ACC_W{1'b0}};
    end else begin
      acc_next_s = acc_r[voice_r] + ACC_W'(act_tune_r[voice_r]);
    end
  end

  // Low phase bits below the waveform resolution are intentionally dropped.
  assign unused_s = ^phase_s;

  // Shadow writes from the host; an accepted tick snapshots shadows to active.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        sh_tune_r[v]  <= {TUNE_W{1'b0}};
        sh_ctrl_r[v]  <= 7'd0;
        sh_pw_r[v]    <= {WAVE_W{1'b0}};
        act_tune_r[v] <= {TUNE_W{1'b0}};
        act_ctrl_r[v] <= 7'd0;
        act_pw_r[v]   <= {WAVE_W{1'b0}};
      end
    end else begin
      if (tick_accept_s) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          act_tune_r[v]   <= sh_tune_r[v];
          act_ctrl_r[v]   <= sh_ctrl_r[v];
          act_pw_r[v]     <= sh_pw_r[v];
          sh_ctrl_r[v][1] <= 1'b0;   // phase_reset is a one-shot
        end
      end
      // A write coincident with the snapshot wins in the shadow (next frame).
      if (bus.cfg_we) begin
        case (bus.cfg_field)
          2'd0: sh_tune_r[bus.cfg_voice] <= bus.cfg_data;
          2'd1: sh_ctrl_r[bus.cfg_voice] <= bus.cfg_data[6:0];
          2'd2: sh_pw_r[bus.cfg_voice]   <= bus.cfg_data[TUNE_W-1 -: WAVE_W];
          default: begin end
        endcase
      end
    end
  end

  // Phase accumulators and noise generator advance only when their voice is scanned.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        acc_r[v] <= {ACC_W{1'b0}};
      end
      lfsr_r <= LFSR_SEED;
    end else if (state_r == ST_SCAN) begin
      acc_r[voice_r] <= acc_next_s;
      if (noise_step_s) begin
        lfsr_r <= lfsr_step(lfsr_r);
      end
    end
  end

  // Frame sequencer: IDLE -> SCAN (one voice per cycle) -> DONE -> IDLE.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      voice_r      <= {VOICE_W{1'b0}};
      sum_r        <= {SUM_W{1'b0}};
      out_sample_r <= OUT_MID;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (bus.sample_tick && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (tick_accept_s) begin
            state_r <= ST_SCAN;
            voice_r <= {VOICE_W{1'b0}};
            sum_r   <= {SUM_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        ST_SCAN: begin
          sum_r <= sum_next_s;
          if (voice_r == LAST_VOICE) begin
            state_r      <= ST_DONE;
            out_sample_r <= out_word_s;
            out_valid_r  <= 1'b1;
          end else begin
            voice_r <= voice_r + VOICE_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_sample = out_sample_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.busy       = busy_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_dds_voice_engine.sv
// Self-checking bench for dds_voice_engine: a directed vector table,
// hand-written multi-cycle sequences, and randomized frames checked
// against a frame-level arithmetic model of the voice engine.
module tb_dds_voice_engine;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_voice_engine_if #(.NUM_VOICES(N), .TUNE_W(16), .OUT_W(16)) bus ();

  dds_voice_engine #(
    .NUM_VOICES(N), .TUNE_W(16), .ACC_W(20), .PHASE_W(14), .WAVE_W(12), .OUT_W(16)
  ) dut (
    .sys_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int sh_tune[N], sh_ctrl[N], sh_pw[N];
  int act_tune[N], act_ctrl[N], act_pw[N];
  int m_acc[N];
  int m_lfsr;

  typedef struct {
    int tune; int ctrl; int pw; int frames; int exp;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      sh_tune[i] = 0; sh_ctrl[i] = 0; sh_pw[i] = 0;
      act_tune[i] = 0; act_ctrl[i] = 0; act_pw[i] = 0; m_acc[i] = 0;
    end
    m_lfsr = 16'hACE1;
  endfunction

  function automatic void model_write(input int v, input int f, input int d);
    case (f)
      0: sh_tune[v] = d & 16'hFFFF;
      1: sh_ctrl[v] = d & 7'h7F;
      2: sh_pw[v]   = (d & 16'hFFFF) >> 4;
      default: ;
    endcase
  endfunction

  function automatic void model_tick(input bit wr, input int v, input int f, input int d);
    for (int i = 0; i < N; i++) begin
      act_tune[i] = sh_tune[i]; act_ctrl[i] = sh_ctrl[i]; act_pw[i] = sh_pw[i];
      sh_ctrl[i] = sh_ctrl[i] & ~2;
    end
    if (wr) model_write(v, f, d);
  endfunction

  // One whole frame: returns the expected offset-binary output word.
  function automatic int model_frame();
    int sum = 0;
    for (int v = 0; v < N; v++) begin
      int c, ph, t, w, s, fb;
      c = act_ctrl[v];
      if ((c & 1) != 0) begin
        if ((c & 2) != 0) begin
          ph = 0; m_acc[v] = 0;
        end else begin
          ph = m_acc[v] / 64;
          m_acc[v] = (m_acc[v] + act_tune[v]) % (1 << 20);
        end
        t = ph / 4;
        case ((c >> 2) & 7)
          0: w = t;
          1: w = (t < act_pw[v]) ? 4095 : 0;
          2: w = (ph >= 8192) ? 4095 - ((ph / 2) % 4096) : (ph / 2) % 4096;
          3: begin
            w = m_lfsr / 16;
            fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
          end
          default: w = 2048;
        endcase
        s = (w - 2048) >>> ((c >> 5) & 3);
        sum += s;
      end
    end
    return sum * 4 + 32768;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int v, input int f, input int d);
    bus.cfg_we = 1'b1; bus.cfg_voice = 2'(v); bus.cfg_field = 2'(f); bus.cfg_data = 16'(d);
    step();
    bus.cfg_we = 1'b0;
    model_write(v, f, d);
  endtask

  // Tick (optionally with a coincident config write), wait for the sample.
  task automatic run_frame(input bit wr, input int v, input int f, input int d, output int got);
    int exp, lat;
    bus.sample_tick = 1'b1;
    if (wr) begin
      bus.cfg_we = 1'b1; bus.cfg_voice = 2'(v); bus.cfg_field = 2'(f); bus.cfg_data = 16'(d);
    end
    model_tick(wr, v, f, d);
    exp = model_frame();
    step();
    bus.sample_tick = 1'b0; bus.cfg_we = 1'b0;
    chk("busy_start", bus.busy, 1);
    lat = 0; got = -1;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      if (bus.out_valid) begin
        lat = k; got = bus.out_sample;
      end else begin
        step();
      end
    end
    chk("valid_latency", lat, N + 1);
    chk("frame_sample", got, exp);
    chk("busy_at_valid", bus.busy, 1);
    step();
    chk("idle_after", {bus.busy, bus.out_valid}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int got, first, exp, nvalid;

    tbl[0]  = '{0,       8'h01, 0,       1, 16'h6000};
    tbl[1]  = '{0,       8'h05, 16'h0800, 1, 16'h9FFC};
    tbl[2]  = '{0,       8'h05, 0,       1, 16'h6000};
    tbl[3]  = '{0,       8'h09, 0,       1, 16'h6000};
    tbl[4]  = '{0,       8'h11, 0,       1, 16'h8000};
    tbl[5]  = '{16'h1000, 8'h00, 0,       1, 16'h8000};
    tbl[6]  = '{0,       8'h61, 0,       1, 16'h7C00};
    tbl[7]  = '{0,       8'h25, 16'hFFFF, 1, 16'h8FFC};
    tbl[8]  = '{0,       8'h0D, 0,       1, 16'h8B38};
    tbl[9]  = '{16'h1000, 8'h01, 0,       2, 16'h6040};
    tbl[10] = '{16'h8000, 8'h05, 16'h0800, 2, 16'h6000};
    tbl[11] = '{16'h8000, 8'h09, 0,       3, 16'h6800};
    tbl[12] = '{0,       8'h0D, 0,       2, 16'h759C};

    rst = 1'b1;
    bus.sample_tick = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_voice = 2'd0; bus.cfg_field = 2'd0; bus.cfg_data = 16'd0;
    do_reset();

    // Reset state and an all-silent frame
    chk("rst_sample", bus.out_sample, 16'h8000);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    run_frame(1'b0, 0, 0, 0, got);
    chk("silent_sample", got, 16'h8000);
    chk("silent_overrun", bus.overrun, 0);

    // Directed vector table: voice 0 alone
    foreach (tbl[i]) begin
      do_reset();
      cfg_write(0, 0, tbl[i].tune);
      cfg_write(0, 1, tbl[i].ctrl);
      cfg_write(0, 2, tbl[i].pw);
      for (int f = 0; f < tbl[i].frames; f++) run_frame(1'b0, 0, 0, 0, got);
      chk($sformatf("table_%0d", i), got, tbl[i].exp);
    end

    // Write coincident with tick applies one frame later
    do_reset();
    cfg_write(0, 0, 16'h1000);
    cfg_write(0, 1, 8'h01);
    run_frame(1'b0, 0, 0, 0, got);
    chk("tune_f1", got, 16'h6000);
    run_frame(1'b1, 0, 0, 16'h2000, got);
    chk("tune_f2_old", got, 16'h6040);
    run_frame(1'b0, 0, 0, 0, got);
    chk("tune_f3", got, 16'h6080);
    run_frame(1'b0, 0, 0, 0, got);
    chk("tune_f4_new", got, 16'h6100);

    // phase_reset: next frame at phase 0, then self-cleared
    cfg_write(0, 1, 8'h03);
    run_frame(1'b0, 0, 0, 0, got);
    chk("preset_f1", got, 16'h6000);
    run_frame(1'b0, 0, 0, 0, got);
    chk("preset_f2", got, 16'h6000);
    run_frame(1'b0, 0, 0, 0, got);
    chk("preset_cleared", got, 16'h6080);

    // Tick while busy: ignored, overrun sticky
    model_tick(1'b0, 0, 0, 0);
    exp = model_frame();
    bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step();
    bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0;
    nvalid = 0; got = -1;
    for (int k = 0; k < 10; k++) begin
      if (bus.out_valid) begin nvalid++; got = bus.out_sample; end
      step();
    end
    chk("overrun_valid_count", nvalid, 1);
    chk("overrun_sample", got, exp);
    chk("overrun_set", bus.overrun, 1);
    cfg_write(2, 1, 8'h0D);
    run_frame(1'b0, 0, 0, 0, got);
    chk("overrun_sticky", bus.overrun, 1);

    // Reset mid-frame: no sample, state cleared, LFSR reseeded
    bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) nvalid++;
      step();
    end
    chk("abort_no_valid", nvalid, 0);
    chk("abort_sample", bus.out_sample, 16'h8000);
    chk("abort_busy", bus.busy, 0);
    chk("abort_overrun", bus.overrun, 0);
    cfg_write(2, 1, 8'h0D);
    run_frame(1'b0, 0, 0, 0, got);
    chk("lfsr_reseed", got, 16'h8B38);

    // Accumulator wraps silently after 256 frames of tune 0x1000
    do_reset();
    cfg_write(0, 0, 16'h1000);
    cfg_write(0, 1, 8'h01);
    run_frame(1'b0, 0, 0, 0, first);
    for (int f = 1; f < 256; f++) run_frame(1'b0, 0, 0, 0, got);
    run_frame(1'b0, 0, 0, 0, got);
    chk("acc_wrap", got, first);

    // Randomized multi-voice frames against the model
    do_reset();
    for (int f = 0; f < 80; f++) begin
      int nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        cfg_write($urandom_range(0, N - 1), $urandom_range(0, 3), $urandom_range(0, 16'hFFFF));
      end
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, 3),
                $urandom_range(0, 16'hFFFF), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
